i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

Upstream stage of the I2C write engine. Walks an external register table of (sub-address, data) pairs and issues one 24-bit write per entry to the I2C controller using its GO/END/ACK handshake. Generates the slow controller clock from the system clock, retries NACKed writes, and reports completion and error status to the system.

## Interface
- CLK_FREQ, 50_000_000: CLOCK frequency in Hz.
- I2C_FREQ, 20_000: controller clock frequency in Hz. DIV_HALF = CLK_FREQ/(2*I2C_FREQ), must be ≥2.
- SLAVE_ADDR, 8'h42: 8-bit write address (R/W bit = 0), placed in I2C_DATA[23:16].
- LUT_SIZE, 16: number of table entries, 1..256.
- MAX_RETRY, 3: extra attempts per entry after a failure.
- TIMEOUT, 64: controller-clock periods allowed for END after GO.
- AUTO_START, 1: run the table once after reset.
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-CLOCK pulse; (re)runs the table from entry 0 when not busy.
- LUT_INDEX  out  8  current table index.
- LUT_DATA  in  16  {sub_addr, data} for LUT_INDEX, combinational ROM read.
- I2C_CTRL_CLK  out  1  divided clock; drives both CLOCK and Clk_O of the controller.
- I2C_DATA  out  24  {SLAVE_ADDR, LUT_DATA} latched for the current write.
- GO  out  1  controller start, level.
- I2C_END  in  1  controller transfer complete.
- I2C_ACK  in  1  controller NACK flag (1 = failure).
- BUSY  out  1  sequence in progress.
- DONE  out  1  sequence finished; held until next start.
- ERROR  out  1  entry exhausted retries; held until next start.

## Operation
- Divider: counter 0..DIV_HALF-1; on wrap I2C_CTRL_CLK toggles. tick = wrap while I2C_CTRL_CLK==1, i.e. the falling edge. The FSM advances only on tick, so GO/I2C_DATA are stable half a period before the controller's rising edge.
- States: IDLE, LOAD, WAIT_END, GAP, NEXT, FINISH.
- IDLE: on START (latched in a CLOCK-domain pending flag until the next tick), or on the first tick after reset when AUTO_START=1: LUT_INDEX=0, retry=0, DONE=0, ERROR=0, BUSY=1, go to LOAD.
- LOAD: I2C_DATA <= {SLAVE_ADDR, LUT_DATA}, GO=1, clear the seen_low flag and the timeout counter, go to WAIT_END.
- WAIT_END: each tick, set seen_low if I2C_END==0 and increment timeout. Success is I2C_END==1 with seen_low and I2C_ACK==0. Failure is I2C_END==1 with seen_low and I2C_ACK==1, or timeout==TIMEOUT. Either outcome sets GO=0 and goes to GAP.
- GAP: GO held 0 for exactly 2 ticks so the controller counter and END clear. Then: success goes to NEXT. Failure with retry<MAX_RETRY does retry+1 and goes to LOAD. Failure with retries exhausted sets ERROR=1 and goes to FINISH (abort, no further entries).
- NEXT: retry=0. If LUT_INDEX==LUT_SIZE-1, go to FINISH; else LUT_INDEX+1 and go to LOAD.
- FINISH: BUSY=0, DONE=1, GO=0, go to IDLE. LUT_INDEX keeps the last entry attempted.
- START while BUSY is ignored (pending flag not set).
- Reset, asynchronous and at any time including mid-transfer: every output goes to 0 (LUT_INDEX, I2C_DATA, GO, I2C_CTRL_CLK, BUSY, DONE, ERROR). The divider, pending, retry and timeout counters clear and the FSM enters IDLE. The controller sees GO=0 and aborts.

## Timing
- The FSM's minimum per-entry cost is LOAD (1 tick) + WAIT_END (≥ controller transfer, about 33 ticks) + GAP (2) + NEXT (1).
- GO rises on a tick and changes only on ticks.
- I2C_DATA changes only in LOAD and only while GO=0.
- START-to-BUSY latency is at most 2·DIV_HALF CLOCK cycles.
- DONE and BUSY=0 change on the same CLOCK edge.
- A stale END=1 from a previous transfer is never accepted, because seen_low is required.

## Test plan
Sim parameters: CLK_FREQ=8, I2C_FREQ=1 (DIV_HALF=4), LUT_SIZE=3, MAX_RETRY=2, TIMEOUT=40, controller model attached.
- Reset: all outputs are 0 during RESET=0. I2C_CTRL_CLK period is 8 CLOCK cycles after release.
- Normal run, table {16'h1280, 16'h0C04, 16'h3A04}, ACK always 0: three GO pulses with I2C_DATA = 24'h421280, 24'h420C04, 24'h423A04 in order. Then DONE=1, ERROR=0, BUSY=0.
- Single NACK on entry 1: entry 1 is issued twice with identical I2C_DATA. Entry 2 follows and the run ends with DONE=1, ERROR=0.
- Persistent NACK on entry 0: exactly 3 GO pulses, then ERROR=1, DONE=1, LUT_INDEX=0, and entry 1 is never issued.
- END stuck at 0: timeout after 40 ticks, 3 attempts total, ERROR=1.
- START pulsed mid-run is ignored. START after DONE reruns from index 0 and clears DONE/ERROR. RESET asserted during entry 1 forces GO=0 immediately, then a clean AUTO_START run follows after release.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Register-table write sequencer for the I2C controller: walks (sub_addr, data) entries,
// issues one 24-bit GO/END/ACK write per entry, retries NACKs and reports DONE/ERROR.
module i2c_reg_sequencer #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 20_000,
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int         LUT_SIZE   = 16,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 64,
    parameter logic       AUTO_START = 1'b1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    output logic [7:0]  LUT_INDEX,
    input  logic [15:0] LUT_DATA,
    output logic        I2C_CTRL_CLK,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    input  logic        I2C_END,
    input  logic        I2C_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    localparam int DIV_HALF = CLK_FREQ / (2 * I2C_FREQ);
    localparam int DIV_W    = (DIV_HALF > 2) ? $clog2(DIV_HALF) : 1;
    localparam int TO_W     = $clog2(TIMEOUT + 2);
    localparam int RT_W     = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_WAIT_END = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;
    logic             tick;
    logic             start_pend;
    logic             auto_pend;
    logic             start_req;
    logic [2:0]       state;
    logic [TO_W-1:0]  timeout;
    logic [RT_W-1:0]  retry;
    logic             seen_low;
    logic             fail;
    logic             gap_cnt;

    assign wrap = (div_cnt == DIV_W'(DIV_HALF - 1));
    // The FSM steps on the falling edge of the controller clock, so GO and I2C_DATA
    // settle half a period before the controller samples them.
    assign tick = wrap && I2C_CTRL_CLK;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            div_cnt      <= '0;
            I2C_CTRL_CLK <= 1'b0;
        end else if (wrap) begin
            div_cnt      <= '0;
            I2C_CTRL_CLK <= ~I2C_CTRL_CLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // START is a one-CLOCK pulse; hold it until the next tick so it is never missed.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            start_pend <= 1'b0;
            auto_pend  <= AUTO_START;
        end else if (tick) begin
            start_pend <= 1'b0;
            auto_pend  <= 1'b0;
        end else if (START && !BUSY) begin
            start_pend <= 1'b1;
        end
    end

    assign start_req = start_pend || auto_pend || (START && !BUSY);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            LUT_INDEX <= 8'd0;
            I2C_DATA  <= 24'd0;
            GO        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            timeout   <= '0;
            retry     <= '0;
            seen_low  <= 1'b0;
            fail      <= 1'b0;
            gap_cnt   <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        LUT_INDEX <= 8'd0;
                        retry     <= '0;
                        DONE      <= 1'b0;
                        ERROR     <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    I2C_DATA <= {SLAVE_ADDR, LUT_DATA};
                    GO       <= 1'b1;
                    seen_low <= 1'b0;
                    timeout  <= '0;
                    state    <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (!I2C_END) seen_low <= 1'b1;
                    timeout <= timeout + 1'b1;
                    // seen_low rejects an END still high from the previous transfer
                    if (I2C_END && seen_low) begin
                        fail    <= I2C_ACK;
                        GO      <= 1'b0;
                        gap_cnt <= 1'b0;
                        state   <= S_GAP;
                    end else if (timeout == TO_W'(TIMEOUT)) begin
                        fail    <= 1'b1;
                        GO      <= 1'b0;
                        gap_cnt <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!gap_cnt) begin
                        gap_cnt <= 1'b1;
                    end else if (!fail) begin
                        state <= S_NEXT;
                    end else if (retry < RT_W'(MAX_RETRY)) begin
                        retry <= retry + 1'b1;
                        state <= S_LOAD;
                    end else begin
                        ERROR <= 1'b1;
                        state <= S_FINISH;
                    end
                end
                S_NEXT: begin
                    retry <= '0;
                    if (LUT_INDEX == 8'(LUT_SIZE - 1)) begin
                        state <= S_FINISH;
                    end else begin
                        LUT_INDEX <= LUT_INDEX + 8'd1;
                        state     <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    GO    <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural I2C controller attached;
// every step compares against hand-computed values via immediate assertions.
module tb_i2c_reg_sequencer;

    localparam int DIV_HALF = 4;
    localparam int XFER     = 6;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  LUT_INDEX;
    logic [15:0] LUT_DATA;
    logic        I2C_CTRL_CLK;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        I2C_END;
    logic        I2C_ACK;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    logic [15:0] lut [3] = '{16'h1280, 16'h0C04, 16'h3A04};
    assign LUT_DATA = (LUT_INDEX < 8'd3) ? lut[LUT_INDEX[1:0]] : 16'h0000;

    i2c_reg_sequencer #(
        .CLK_FREQ(8), .I2C_FREQ(1), .SLAVE_ADDR(8'h42), .LUT_SIZE(3),
        .MAX_RETRY(2), .TIMEOUT(40), .AUTO_START(1'b1)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .LUT_INDEX(LUT_INDEX),
        .LUT_DATA(LUT_DATA), .I2C_CTRL_CLK(I2C_CTRL_CLK), .I2C_DATA(I2C_DATA),
        .GO(GO), .I2C_END(I2C_END), .I2C_ACK(I2C_ACK), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLOCK = ~CLOCK;

    // Controller model: END idles high, drops for XFER controller clocks after GO.
    logic stuck_low  = 1'b0;
    int   nack_entry = -1;
    int   nack_times = 0;
    int   attempts   = 0;
    int   m_cnt      = 0;
    logic m_end      = 1'b1;
    logic m_ack      = 1'b0;

    assign I2C_END = stuck_low ? 1'b0 : m_end;
    assign I2C_ACK = m_ack;

    always @(posedge I2C_CTRL_CLK) begin
        if (!GO) begin
            m_cnt <= 0;
            m_end <= 1'b1;
            m_ack <= 1'b0;
        end else if (m_cnt < XFER) begin
            m_cnt <= m_cnt + 1;
            m_end <= 1'b0;
        end else begin
            m_end <= 1'b1;
            m_ack <= (nack_entry == int'(LUT_INDEX)) && (attempts <= nack_times);
        end
    end

    // Observer: logs every GO pulse and counts handshake-rule violations.
    logic        go_q = 1'b0, busy_q = 1'b0, done_q = 1'b0, ctrl_q = 1'b0, rst_q = 1'b0;
    logic [23:0] data_q = 24'h0;
    logic [23:0] data_log [$];
    int          last_idx = -1;
    int          go_len = 0, last_go_len = 0;
    int          data_viol = 0, go_tick_viol = 0, done_viol = 0;

    always @(negedge CLOCK) begin
        if (BUSY && !busy_q) begin
            attempts <= 0;
            last_idx <= -1;
        end else if (GO && !go_q) begin
            data_log.push_back(I2C_DATA);
            attempts <= (int'(LUT_INDEX) == last_idx) ? attempts + 1 : 1;
            last_idx <= int'(LUT_INDEX);
        end
        if (GO) begin
            go_len <= go_len + 1;
        end else if (go_q) begin
            last_go_len <= go_len;
            go_len      <= 0;
        end
        if (RESET && rst_q) begin
            if (GO && go_q && I2C_DATA !== data_q) data_viol <= data_viol + 1;
            if (GO !== go_q && !(ctrl_q && !I2C_CTRL_CLK)) go_tick_viol <= go_tick_viol + 1;
            if (DONE && !done_q && !(busy_q && !BUSY)) done_viol <= done_viol + 1;
        end
        go_q   <= GO;
        busy_q <= BUSY;
        done_q <= DONE;
        ctrl_q <= I2C_CTRL_CLK;
        rst_q  <= RESET;
        data_q <= I2C_DATA;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input string tag);
        int n = 0;
        @(negedge CLOCK);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        while (!BUSY && n < 50) begin
            @(negedge CLOCK);
            n++;
        end
        check({tag, "_start_latency_ok"}, 32'(n <= 2 * DIV_HALF), 32'd1);
        check({tag, "_done_cleared"}, 32'(DONE), 32'd0);
        check({tag, "_error_cleared"}, 32'(ERROR), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!DONE && n < 4000) begin
            @(negedge CLOCK);
            n++;
        end
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_busy_low"}, 32'(BUSY), 32'd0);
        check({tag, "_go_low"}, 32'(GO), 32'd0);
    endtask

    task automatic measure_period(output int p);
        int   n = 0;
        logic prev;
        prev = I2C_CTRL_CLK;
        while (!(I2C_CTRL_CLK && !prev) && n < 40) begin
            prev = I2C_CTRL_CLK;
            @(negedge CLOCK);
            n++;
        end
        p = 0;
        prev = I2C_CTRL_CLK;
        do begin
            prev = I2C_CTRL_CLK;
            @(negedge CLOCK);
            p++;
        end while (!(I2C_CTRL_CLK && !prev) && p < 40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1);
    end

    initial begin
        int n0;
        int per;
        int n;

        // Reset state
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst_go", 32'(GO), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        check("rst_index", 32'(LUT_INDEX), 32'd0);
        check("rst_data", 32'(I2C_DATA), 32'd0);
        check("rst_ctrl_clk", 32'(I2C_CTRL_CLK), 32'd0);

        // Auto-start normal run, all ACKs good
        n0 = data_log.size();
        RESET = 1'b1;
        measure_period(per);
        check("ctrl_clk_period", 32'(per), 32'd8);
        wait_done("normal");
        check("normal_error", 32'(ERROR), 32'd0);
        check("normal_index", 32'(LUT_INDEX), 32'd2);
        check("normal_go_count", 32'(data_log.size() - n0), 32'd3);
        check("normal_data0", 32'(data_log[n0]),     32'h421280);
        check("normal_data1", 32'(data_log[n0 + 1]), 32'h420C04);
        check("normal_data2", 32'(data_log[n0 + 2]), 32'h423A04);

        // One NACK on entry 1, plus a START pulse mid-run that must be ignored
        nack_entry = 1;
        nack_times = 1;
        n0 = data_log.size();
        start_run("nack1");
        repeat (20) @(negedge CLOCK);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        wait_done("nack1");
        check("nack1_error", 32'(ERROR), 32'd0);
        check("nack1_go_count", 32'(data_log.size() - n0), 32'd4);
        check("nack1_data0", 32'(data_log[n0]),     32'h421280);
        check("nack1_data1", 32'(data_log[n0 + 1]), 32'h420C04);
        check("nack1_data1_retry", 32'(data_log[n0 + 2]), 32'h420C04);
        check("nack1_data2", 32'(data_log[n0 + 3]), 32'h423A04);
        repeat (40) @(negedge CLOCK);
        check("mid_start_ignored_busy", 32'(BUSY), 32'd0);
        check("mid_start_ignored_go", 32'(data_log.size() - n0), 32'd4);
        check("mid_start_done_held", 32'(DONE), 32'd1);

        // Persistent NACK on entry 0: three attempts then abort
        nack_entry = 0;
        nack_times = 100;
        n0 = data_log.size();
        start_run("nack0");
        wait_done("nack0");
        check("nack0_error", 32'(ERROR), 32'd1);
        check("nack0_index", 32'(LUT_INDEX), 32'd0);
        check("nack0_go_count", 32'(data_log.size() - n0), 32'd3);
        check("nack0_data0", 32'(data_log[n0]),     32'h421280);
        check("nack0_data1", 32'(data_log[n0 + 1]), 32'h421280);
        check("nack0_data2", 32'(data_log[n0 + 2]), 32'h421280);

        // END stuck low: each attempt times out after about 40 ticks
        nack_entry = -1;
        stuck_low  = 1'b1;
        n0 = data_log.size();
        start_run("stuck");
        wait_done("stuck");
        check("stuck_error", 32'(ERROR), 32'd1);
        check("stuck_index", 32'(LUT_INDEX), 32'd0);
        check("stuck_go_count", 32'(data_log.size() - n0), 32'd3);
        check("stuck_go_len_ok", 32'(last_go_len >= 320 && last_go_len <= 336), 32'd1);
        stuck_low = 1'b0;

        // Reset during entry 1, then a clean auto-start run
        start_run("rstmid");
        n = 0;
        while (!(LUT_INDEX == 8'd1 && GO) && n < 2000) begin
            @(negedge CLOCK);
            n++;
        end
        check("rstmid_reached_entry1", 32'(LUT_INDEX == 8'd1 && GO), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("rstmid_go", 32'(GO), 32'd0);
        check("rstmid_busy", 32'(BUSY), 32'd0);
        check("rstmid_index", 32'(LUT_INDEX), 32'd0);
        check("rstmid_data", 32'(I2C_DATA), 32'd0);
        check("rstmid_ctrl_clk", 32'(I2C_CTRL_CLK), 32'd0);
        repeat (3) @(negedge CLOCK);
        n0 = data_log.size();
        RESET = 1'b1;
        wait_done("post_rst");
        check("post_rst_error", 32'(ERROR), 32'd0);
        check("post_rst_go_count", 32'(data_log.size() - n0), 32'd3);
        check("post_rst_data0", 32'(data_log[n0]),     32'h421280);
        check("post_rst_data2", 32'(data_log[n0 + 2]), 32'h423A04);

        // Handshake rules over the whole run
        check("data_stable_while_go", 32'(data_viol), 32'd0);
        check("go_changes_on_tick", 32'(go_tick_viol), 32'd0);
        check("done_with_busy_fall", 32'(done_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
